mem_read_arbiter: RTL

Round-robin arbiter and read sequencer for the shared main-memory read port of the message-matching engine. It accepts read descriptors (base word address and length in words) from up to four requesters, grants one at a time, and drives chipselect/mem_addr word by word. It returns each memory word tagged with requester ID, word index and a last flag, and honours a downstream hold.

---
 rtl/mem_read_arbiter.sv | 94 +++++++++
 1 files changed

// File: rtl/mem_read_arbiter.sv
// mem_read_arbiter: round-robin grant of read descriptors, word-by-word memory issue, tagged data return
module mem_read_arbiter #(
  parameter int ID_W = 2,
  parameter int data_width = 32,
  localparam int NUM_REQ = 2**ID_W
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*data_width-1:0] req_desc,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          hold,
  output logic                          out_valid,
  output logic [data_width-1:0]         out_data,
  output logic [ID_W-1:0]               out_id,
  output logic [10:0]                   out_tag,
  output logic                          out_last,
  output logic                          busy,
  output logic                          chipselect,
  output logic [19:0]                   mem_addr,
  input  logic [data_width-1:0]         data_from_mem
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
  state_t state, state_n;
  logic [ID_W-1:0] rr_ptr, id_q, gnt, idx;
  logic found, issue, last_issue, issued_q, last_q, unused_bits;
  logic [10:0] base_q, size_q, k_q, addr_q, addr, tag_q, gnt_base, gnt_size;
  logic [data_width-1:0] gnt_desc;
  always_comb begin
    found = 1'b0;
    gnt = rr_ptr;
    idx = rr_ptr;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = rr_ptr + ID_W'(i);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        gnt = idx;
      end
    end
  end
  assign gnt_desc = req_desc[gnt*data_width +: data_width];
  assign gnt_base = gnt_desc[21:11];
  assign gnt_size = gnt_desc[10:0];
  assign unused_bits = ^gnt_desc[data_width-1:22];
  assign issue = state == ISSUE && !hold;
  assign last_issue = issue && k_q == size_q - 11'd1;
  assign addr = base_q + k_q;
  // reset gating keeps the combinational grant quiet while reset is held
  assign req_ready = (state == IDLE && found && !reset) ? NUM_REQ'(1) << gnt : '0;
  assign chipselect = issue;
  assign mem_addr = {9'b0, issue ? addr : addr_q};
  assign busy = state != IDLE;
  assign out_valid = issued_q;
  assign out_data = data_from_mem;
  assign out_id = id_q;
  assign out_tag = tag_q;
  assign out_last = last_q;
  always_comb begin
    state_n = state;
    if (state == IDLE && found && gnt_size != '0) state_n = ISSUE;
    if (last_issue) state_n = DRAIN;
    if (state == DRAIN) state_n = IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      rr_ptr <= '0;
      id_q <= '0;
      base_q <= '0;
      size_q <= '0;
      k_q <= '0;
      addr_q <= '0;
      tag_q <= '0;
      issued_q <= 1'b0;
      last_q <= 1'b0;
    end else begin
      state <= state_n;
      issued_q <= issue;
      last_q <= last_issue;
      if (state == IDLE && found) begin
        rr_ptr <= gnt + 1'b1;
        id_q <= gnt;
        base_q <= gnt_base;
        size_q <= gnt_size;
        k_q <= '0;
      end
      if (issue) begin
        k_q <= k_q + 11'd1;
        addr_q <= addr;
        tag_q <= k_q;
      end
    end
  end
endmodule
